prga: RTL and testbench
=======================

# prga

RC4 pseudo-random generation stage: consumes the 256-byte state array S produced by the key-scheduling stage and decrypts a length-prefixed ciphertext into plaintext memory. It sits directly downstream of key scheduling in the ARC4 datapath. The top level starts it once key scheduling reports ready. It owns the S, ciphertext (CT) and plaintext (PT) memory ports during operation.

## Interface
- No parameters.
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  8  CT memory address (read-only)
- ct_rddata  in  8  CT memory read data
- pt_addr  out  8  PT memory address
- pt_rddata  in  8  unused; present for memory symmetry
- pt_wrdata  out  8  PT memory write data
- pt_wren  out  1  PT memory write enable

## Operation
- All memories are synchronous single-port: the address is registered at a posedge, and read data is valid during the following cycle.
- Message format:
  - ct[0] holds length L (0..255); ct[1..L] hold the ciphertext bytes.
  - Output is pt[0]=L and pt[k]=pad_k ^ ct[k].
- Algorithm, with i, j, k as 8-bit registers and all sums mod 256 by natural truncation:
  - i=0, j=0.
  - For k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[S[i]+S[j]].
- States and per-state outputs (unlisted outputs are 0):
  - IDLE: rdy=1. Clears i, j, k. en=1 → RD_LEN.
  - RD_LEN: ct_addr=0 → WR_LEN.
  - WR_LEN: latch L=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1. If L==0 → IDLE; else k=1 → RD_SI.
  - RD_SI: s_addr=i+1, ct_addr=k; i<=i+1 → RD_SJ.
  - RD_SJ: si<=s_rddata; ctk<=ct_rddata; s_addr=j+s_rddata; j<=j+s_rddata → WR_SI.
  - WR_SI: sj<=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1 → WR_SJ.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1 → RD_PAD.
  - RD_PAD: s_addr=si+sj → WR_PT.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata^ctk, pt_wren=1. If k==L → IDLE; else k<=k+1 → RD_SI.
- Boundary cases:
  - i==j: the swap writes the same value twice, and the result is correct.
  - Index sums wrap silently at 256.
  - L=255 runs k up to 255 with no overflow.
- en while rdy=0 is ignored and is not queued.

## Timing
- Reset: rst_n=0 at a posedge forces IDLE regardless of state. After reset, rdy=1 and all addresses, wrdata and wrens are 0.
- Reset mid-operation aborts immediately. Partially updated S and PT are left as-is, with no cleanup.
- Start: a posedge with en=1 and rdy=1 enters RD_LEN. rdy is low from the next cycle for exactly 2+6L cycles.
- Each message byte costs 6 cycles: RD_SI through WR_PT.
- All outputs are a combinational decode of the state and registers. A write occurs at the posedge ending the cycle in which wren=1.
- S and CT reads never overlap a write to the same memory in the same cycle.

## Structure
- Shared package rc4_pkg holds:
  - the prga state enum;
  - CT_LEN_ADDR=8'd0 and PT_LEN_ADDR=8'd0;
  - RC4_BYTE_W=8.
- Single module with one sequential FSM process and one combinational output decode. No sub-module is needed; the byte-swap sequencing is inherent to the FSM.

## Test plan
- Reset and idle: hold rst_n=0 for 2 cycles, then release → rdy=1, s_wren=pt_wren=0, all addresses 0. en held low → nothing changes for 20 cycles.
- Empty message: identity S, ct[0]=0, one-cycle en pulse → pt[0]=0, rdy low for exactly 2 cycles, S unmodified.
- Single byte: identity S (S[x]=x), ct={1,0x00} → pt={1,0x02}, S still identity (i=j=1), rdy low for 8 cycles.
- Two bytes: identity S, ct={2,0xFF,0x00} → pt={2,0xFD,0x05}. Afterwards S[2]=3 and S[3]=2; rdy low for 14 cycles.
- Wrap-around: identity S except S[1]=0xFF and S[0xFF]=0x01; ct={1,0xA5} → j=0xFF, pad address 0x00, pt[1]=0xA5. Afterwards S[1]=0x01 and S[0xFF]=0xFF.
- Abort and busy-en:
  - Start ct={3,...}; pulse en during RD_SJ → ignored, rdy stays low.
  - Assert rst_n=0 during WR_SJ of byte 2 → next cycle IDLE, rdy=1, no further writes.
  - A fresh en after the abort runs to completion.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared ARC4 datapath definitions: byte width, fixed length-byte addresses
// and the PRGA state encoding.
package rc4_pkg;

  localparam int unsigned RC4_BYTE_W = 8;

  typedef logic [RC4_BYTE_W-1:0] rc4_byte_t;

  localparam rc4_byte_t CT_LEN_ADDR = 8'd0;
  localparam rc4_byte_t PT_LEN_ADDR = 8'd0;

  typedef enum logic [3:0] {
    PRGA_IDLE   = 4'd0,
    PRGA_RD_LEN = 4'd1,
    PRGA_WR_LEN = 4'd2,
    PRGA_RD_SI  = 4'd3,
    PRGA_RD_SJ  = 4'd4,
    PRGA_WR_SI  = 4'd5,
    PRGA_WR_SJ  = 4'd6,
    PRGA_RD_PAD = 4'd7,
    PRGA_WR_PT  = 4'd8
  } prga_state_e;

endpackage

// File: rtl/prga.sv
// RC4 pseudo-random generation stage: walks the scheduled S array, swapping
// entries per byte, and XORs the keystream into the length-prefixed message.
module prga
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  prga_state_e state_q, state_d;
  rc4_byte_t   i_q, i_d;
  rc4_byte_t   j_q, j_d;
  rc4_byte_t   k_q, k_d;
  rc4_byte_t   len_q, len_d;
  rc4_byte_t   si_q, si_d;
  rc4_byte_t   sj_q, sj_d;
  rc4_byte_t   ctk_q, ctk_d;

  // PT is write-only here; the read port exists only for memory symmetry.
  logic unused_pt_rddata;
  assign unused_pt_rddata = ^pt_rddata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PRGA_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ctk_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctk_q   <= ctk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ctk_d     = ctk_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    unique case (state_q)
      PRGA_IDLE: begin
        rdy = 1'b1;
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (en) state_d = PRGA_RD_LEN;
      end
      PRGA_RD_LEN: begin
        ct_addr = CT_LEN_ADDR;
        state_d = PRGA_WR_LEN;
      end
      PRGA_WR_LEN: begin
        len_d     = ct_rddata;
        pt_addr   = PT_LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == '0) begin
          state_d = PRGA_IDLE;
        end else begin
          k_d     = 8'd1;
          state_d = PRGA_RD_SI;
        end
      end
      PRGA_RD_SI: begin
        s_addr  = i_q + 8'd1;
        ct_addr = k_q;
        i_d     = i_q + 8'd1;
        state_d = PRGA_RD_SJ;
      end
      PRGA_RD_SJ: begin
        si_d    = s_rddata;
        ctk_d   = ct_rddata;
        s_addr  = j_q + s_rddata;
        j_d     = j_q + s_rddata;
        state_d = PRGA_WR_SI;
      end
      PRGA_WR_SI: begin
        // S[j] arrives now and goes straight into S[i]; S[i] was saved in si.
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = PRGA_WR_SJ;
      end
      PRGA_WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = PRGA_RD_PAD;
      end
      PRGA_RD_PAD: begin
        s_addr  = si_q + sj_q;
        state_d = PRGA_WR_PT;
      end
      PRGA_WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ctk_q;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = PRGA_IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = PRGA_RD_SI;
        end
      end
      default: state_d = PRGA_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga with behavioural synchronous S/CT/PT memories.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_rddata, pt_wrdata;
  logic       pt_wren;

  int tests = 0;
  int fails = 0;

  logic [7:0] s_mem  [0:255];
  logic [7:0] ct_mem [0:255];
  logic [7:0] pt_mem [0:255];
  logic [7:0] s_init [0:255];
  logic [7:0] ct_init[0:255];
  logic [7:0] pt_init[0:255];
  logic       load = 1'b0;

  always #5 clk = ~clk;

  prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always @(posedge clk) begin
    if (load) begin
      s_mem  <= s_init;
      ct_mem <= ct_init;
      pt_mem <= pt_init;
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    pt_rddata <= pt_mem[pt_addr];
  end

  task automatic set_images(input logic [7:0] len, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    for (int x = 0; x < 256; x++) begin
      s_init[x]  = 8'(x);
      ct_init[x] = 8'h00;
      pt_init[x] = 8'hEE;
    end
    ct_init[0] = len;
    ct_init[1] = b1;
    ct_init[2] = b2;
    ct_init[3] = b3;
  endtask

  task automatic load_mems;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic run(output int busy);
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    busy = 0;
    while (rdy == 1'b0 && busy < 5000) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({rdy, s_wren, pt_wren, s_addr, ct_addr, pt_addr, s_wrdata, pt_wrdata} !== {1'b1, 42'd0}) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b s_wren=%b pt_wren=%b s_addr=%h ct_addr=%h pt_addr=%h expected rdy=1 rest 0",
               rdy, s_wren, pt_wren, s_addr, ct_addr, pt_addr);
    end
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rdy !== 1'b1 || s_wren !== 1'b0 || pt_wren !== 1'b0 || s_addr !== 8'h00) ok = 1'b0;
    end
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL idle_stable: activity seen with en low, expected none");
    end
  endtask

  task automatic test_empty;
    int  busy;
    logic ok;
    set_images(8'd0, 8'h00, 8'h00, 8'h00);
    load_mems();
    run(busy);
    tests++;
    if (busy !== 2) begin
      fails++;
      $display("FAIL empty_busy: got %0d cycles, expected 2", busy);
    end
    tests++;
    if (pt_mem[0] !== 8'h00) begin
      fails++;
      $display("FAIL empty_pt0: got %h, expected 00", pt_mem[0]);
    end
    ok = 1'b1;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) ok = 1'b0;
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL empty_s_identity: S modified, expected identity");
    end
  endtask

  task automatic test_single;
    int  busy;
    logic ok;
    set_images(8'd1, 8'h00, 8'h00, 8'h00);
    load_mems();
    run(busy);
    tests++;
    if (busy !== 8) begin
      fails++;
      $display("FAIL single_busy: got %0d cycles, expected 8", busy);
    end
    tests++;
    if ({pt_mem[0], pt_mem[1], pt_mem[2]} !== {8'h01, 8'h02, 8'hEE}) begin
      fails++;
      $display("FAIL single_pt: got %h %h %h, expected 01 02 ee", pt_mem[0], pt_mem[1], pt_mem[2]);
    end
    ok = 1'b1;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) ok = 1'b0;
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL single_s_identity: S modified, expected identity");
    end
  endtask

  task automatic test_two_bytes;
    int busy;
    set_images(8'd2, 8'hFF, 8'h00, 8'h00);
    load_mems();
    run(busy);
    tests++;
    if (busy !== 14) begin
      fails++;
      $display("FAIL two_busy: got %0d cycles, expected 14", busy);
    end
    tests++;
    if ({pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]} !== {8'h02, 8'hFD, 8'h05, 8'hEE}) begin
      fails++;
      $display("FAIL two_pt: got %h %h %h %h, expected 02 fd 05 ee",
               pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]);
    end
    tests++;
    if ({s_mem[1], s_mem[2], s_mem[3], s_mem[5]} !== {8'h01, 8'h03, 8'h02, 8'h05}) begin
      fails++;
      $display("FAIL two_s: got S1=%h S2=%h S3=%h S5=%h, expected 01 03 02 05",
               s_mem[1], s_mem[2], s_mem[3], s_mem[5]);
    end
  endtask

  task automatic test_wrap;
    int busy;
    set_images(8'd1, 8'hA5, 8'h00, 8'h00);
    s_init[1]   = 8'hFF;
    s_init[255] = 8'h01;
    load_mems();
    run(busy);
    tests++;
    if ({pt_mem[0], pt_mem[1]} !== {8'h01, 8'hA5}) begin
      fails++;
      $display("FAIL wrap_pt: got %h %h, expected 01 a5", pt_mem[0], pt_mem[1]);
    end
    tests++;
    if ({s_mem[0], s_mem[1], s_mem[255]} !== {8'h00, 8'h01, 8'hFF}) begin
      fails++;
      $display("FAIL wrap_s: got S0=%h S1=%h Sff=%h, expected 00 01 ff", s_mem[0], s_mem[1], s_mem[255]);
    end
  endtask

  task automatic test_abort;
    int  busy;
    logic ok;
    set_images(8'd3, 8'h11, 8'h22, 8'h33);
    load_mems();
    @(negedge clk) en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) en = 1'b0;
      if (c == 4) en = 1'b1;
      if (c == 5) begin
        en = 1'b0;
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL busy_en_ignored: rdy=%b, expected 0", rdy);
        end
      end
      if (c == 12) rst_n = 1'b0;
    end
    tests++;
    if ({rdy, s_wren, pt_wren, s_addr, pt_addr} !== {1'b1, 18'd0}) begin
      fails++;
      $display("FAIL abort_idle: rdy=%b s_wren=%b pt_wren=%b s_addr=%h pt_addr=%h, expected 1 0 0 00 00",
               rdy, s_wren, pt_wren, s_addr, pt_addr);
    end
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rdy !== 1'b1 || s_wren !== 1'b0 || pt_wren !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL abort_quiet: writes or busy after abort, expected none");
    end
    tests++;
    if ({pt_mem[0], pt_mem[1], pt_mem[2], s_mem[2], s_mem[3]} !== {8'h03, 8'h13, 8'hEE, 8'h03, 8'h02}) begin
      fails++;
      $display("FAIL abort_partial: pt=%h %h %h S2=%h S3=%h, expected 03 13 ee 03 02",
               pt_mem[0], pt_mem[1], pt_mem[2], s_mem[2], s_mem[3]);
    end
    set_images(8'd3, 8'h11, 8'h22, 8'h33);
    load_mems();
    run(busy);
    tests++;
    if (busy !== 20) begin
      fails++;
      $display("FAIL after_abort_busy: got %0d cycles, expected 20", busy);
    end
    tests++;
    if ({pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]} !== {8'h03, 8'h13, 8'h27, 8'h34}) begin
      fails++;
      $display("FAIL after_abort_pt: got %h %h %h %h, expected 03 13 27 34",
               pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]);
    end
  endtask

  task automatic test_max_len;
    int busy;
    set_images(8'd255, 8'h00, 8'h00, 8'h00);
    load_mems();
    run(busy);
    tests++;
    if (busy !== 1532) begin
      fails++;
      $display("FAIL max_busy: got %0d cycles, expected 1532", busy);
    end
    tests++;
    if (pt_mem[0] !== 8'hFF || pt_mem[255] === 8'hEE || pt_mem[1] !== 8'h02) begin
      fails++;
      $display("FAIL max_pt: got pt0=%h pt1=%h pt255=%h, expected ff 02 and pt255 written",
               pt_mem[0], pt_mem[1], pt_mem[255]);
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      s_init[x]  = 8'(x);
      ct_init[x] = 8'h00;
      pt_init[x] = 8'hEE;
    end
    test_reset();
    test_empty();
    test_single();
    test_two_bytes();
    test_wrap();
    test_abort();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
